// File: rtl/mat_mult_pkg.sv
// Shared types and constants for the 2x2 matrix multiplier.
package mat_mult_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned RW_DEF = 32;
  localparam int unsigned STEPS  = 8;
  localparam int unsigned CNT_W  = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step s multiplies A[row][k] * B[k][col] with row = s[2], col = s[1], k = s[0].
  // This yields the order a*e, b*g, a*f, b*h, c*e, d*g, c*f, d*h.
  function automatic logic [1:0] a_idx(input logic [CNT_W-1:0] s);
    return {s[2], s[0]};
  endfunction

  function automatic logic [1:0] b_idx(input logic [CNT_W-1:0] s);
    return {s[0], s[1]};
  endfunction

endpackage

// File: rtl/mat_mult_mac.sv
// Shared signed multiply-accumulate: one product per cycle into an RW-bit accumulator.
module mat_mult_mac
  import mat_mult_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] op_a_i,
  input  logic signed [DW-1:0] op_b_i,
  output logic signed [RW-1:0] sum_o
);

  logic signed [2*DW-1:0] prod;
  logic signed [RW-1:0]   prod_ext;
  logic signed [RW-1:0]   acc_q;
  logic signed [RW-1:0]   acc_d;

  // Full-precision signed product, sign-extended, added to the running sum (wraps mod 2^RW).
  always_comb begin
    prod     = (2*DW)'(op_a_i) * (2*DW)'(op_b_i);
    prod_ext = RW'(prod);
    sum_o    = acc_q + prod_ext;
  end

  // Accumulator next value: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum_o;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mat_mult_2x2fsm.sv
// 2x2 signed matrix multiply C = A * B using one shared MAC over eight steps.
module mat_mult_2x2fsm
  import mat_mult_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [DW-1:0] c,
  input  logic signed [DW-1:0] d,
  input  logic signed [DW-1:0] e,
  input  logic signed [DW-1:0] f,
  input  logic signed [DW-1:0] g,
  input  logic signed [DW-1:0] h,
  output logic signed [RW-1:0] w,
  output logic signed [RW-1:0] x,
  output logic signed [RW-1:0] y,
  output logic signed [RW-1:0] z,
  output logic                 done
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic signed [DW-1:0] ma_q [4];
  logic signed [DW-1:0] mb_q [4];
  logic signed [RW-1:0] res_q [3];
  logic signed [RW-1:0] w_q, x_q, y_q, z_q;
  logic                 done_q;

  logic                 capture;
  logic                 last_step;
  logic                 in_calc;
  logic                 mac_clr;
  logic                 mac_en;
  logic                 res_wr;
  logic signed [DW-1:0] sel_a;
  logic signed [DW-1:0] sel_b;
  logic signed [RW-1:0] mac_sum;

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          last_step = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_calc = (state_q == CALC);
    mac_clr = capture | (in_calc & cnt_q[0]);
    mac_en  = in_calc & ~cnt_q[0];
    res_wr  = in_calc & cnt_q[0] & ~last_step;
    sel_a   = ma_q[a_idx(cnt_q)];
    sel_b   = mb_q[b_idx(cnt_q)];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on the accepting IDLE edge and step counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        ma_q[i] <= '0;
        mb_q[i] <= '0;
      end
    end else if (capture) begin
      cnt_q   <= '0;
      ma_q[0] <= a;
      ma_q[1] <= b;
      ma_q[2] <= c;
      ma_q[3] <= d;
      mb_q[0] <= e;
      mb_q[1] <= f;
      mb_q[2] <= g;
      mb_q[3] <= h;
    end else if (in_calc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Completed dot products for w, x, y; z never needs a slot (see below).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 3; i++) begin
        res_q[i] <= '0;
      end
    end else if (res_wr) begin
      res_q[cnt_q[2:1]] <= mac_sum;
    end
  end

  // Output registers and done pulse; z is taken straight from the MAC sum
  // because its slot would be written on the same edge the outputs load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_step;
      if (last_step) begin
        w_q <= res_q[0];
        x_q <= res_q[1];
        y_q <= res_q[2];
        z_q <= mac_sum;
      end
    end
  end

  mat_mult_mac #(
    .DW(DW),
    .RW(RW)
  ) u_mac (
    .clk   (clk),
    .rst_n (reset),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .op_a_i(sel_a),
    .op_b_i(sel_b),
    .sum_o (mac_sum)
  );

  assign w    = w_q;
  assign x    = x_q;
  assign y    = y_q;
  assign z    = z_q;
  assign done = done_q;

endmodule

// File: tb/tb_mat_mult_2x2fsm.sv
// Scoreboard bench for mat_mult_2x2fsm: stimulus pushes reference products, a monitor pops on done.
module tb_mat_mult_2x2fsm;

  localparam int DW = 16;
  localparam int RW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [DW-1:0] a = '0, b = '0, c = '0, d = '0;
  logic signed [DW-1:0] e = '0, f = '0, g = '0, h = '0;
  logic signed [RW-1:0] w, x, y, z;
  logic done;

  mat_mult_2x2fsm #(
    .DW(DW),
    .RW(RW)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .start(start),
    .a(a), .b(b), .c(c), .d(d),
    .e(e), .f(f), .g(g), .h(h),
    .w(w), .x(x), .y(y), .z(z),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [RW-1:0] w, x, y, z;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   av[4];
  int   bv[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // Reference: plain matrix product in wide integers, then wrapped to RW bits.
  function automatic exp_t model(input int ma[4], input int mb[4], input int cy);
    exp_t r;
    longint s;
    logic signed [RW-1:0] m[4];
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += longint'(ma[i*2+k]) * longint'(mb[k*2+j]);
        m[i*2+j] = RW'(s);
      end
    end
    r.w = m[0]; r.x = m[1]; r.y = m[2]; r.z = m[3];
    r.cyc = cy;
    return r;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  task automatic drive_ops();
    a = DW'(av[0]); b = DW'(av[1]); c = DW'(av[2]); d = DW'(av[3]);
    e = DW'(bv[0]); f = DW'(bv[1]); g = DW'(bv[2]); h = DW'(bv[3]);
  endtask

  task automatic rand_ports(input int lo, input int hi);
    a = DW'(rnd(lo, hi)); b = DW'(rnd(lo, hi)); c = DW'(rnd(lo, hi)); d = DW'(rnd(lo, hi));
    e = DW'(rnd(lo, hi)); f = DW'(rnd(lo, hi)); g = DW'(rnd(lo, hi)); h = DW'(rnd(lo, hi));
  endtask

  task automatic set_ops(input int a0, b0, c0, d0, e0, f0, g0, h0);
    av[0] = a0; av[1] = b0; av[2] = c0; av[3] = d0;
    bv[0] = e0; bv[1] = f0; bv[2] = g0; bv[3] = h0;
  endtask

  // One start pulse; leaves the inputs zeroed right after the capture edge.
  task automatic launch(input bit expect_done, input bit release_rst);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    drive_ops();
    start = 1'b1;
    @(posedge clk);
    #1;
    if (expect_done) sbq.push_back(model(av, bv, cyc));
    start = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    drive_ops();
  endtask

  // Scrambles inputs while waiting for outstanding results, bounded.
  task automatic wait_idle();
    int k = 0;
    while (sbq.size() != 0 && k < 100) begin
      @(negedge clk);
      rand_ports(-32768, 32767);
      k++;
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops and compares on done, checks held outputs otherwise.
  exp_t hold = '{w: 0, x: 0, y: 0, z: 0, cyc: 0};
  bit   prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t ex;
    if (!rst_n) begin
      chk("rst_done", longint'(done), 0);
      chk("rst_w", w, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_z", z, 0);
      hold = '{w: 0, x: 0, y: 0, z: 0, cyc: 0};
      prev_done = 1'b0;
    end else if (done) begin
      chk("done_width", longint'(prev_done), 0);
      chk("done_expected", longint'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        ex = sbq.pop_front();
        chk("w", w, ex.w);
        chk("x", x, ex.x);
        chk("y", y, ex.y);
        chk("z", z, ex.z);
        chk("latency", cyc, ex.cyc + 8);
        hold = ex;
      end
      prev_done = 1'b1;
    end else begin
      chk("hold_w", w, hold.w);
      chk("hold_x", x, hold.x);
      chk("hold_y", y, hold.y);
      chk("hold_z", z, hold.z);
      prev_done = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);

    // Basic, started on the first edge after reset release.
    set_ops(1, 2, 3, 4, 5, 6, 7, 8);
    launch(1'b1, 1'b1);
    wait_idle();

    // Mixed signs.
    set_ops(-3, 7, 0, -20, 4, -5, 20, -1);
    launch(1'b1, 1'b0);
    wait_idle();

    // Extremes.
    set_ops(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    launch(1'b1, 1'b0);
    wait_idle();
    set_ops(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
    launch(1'b1, 1'b0);
    wait_idle();

    // Start while busy is ignored.
    set_ops(2, -1, 5, 3, -4, 6, 9, -7);
    launch(1'b1, 1'b0);
    @(negedge clk); rand_ports(-100, 100);
    @(negedge clk); rand_ports(-100, 100);
    @(negedge clk); rand_ports(-100, 100); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_idle();

    // Reset abort at N+4, then a normal operation.
    set_ops(11, 12, 13, 14, 15, 16, 17, 18);
    launch(1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    set_ops(rnd(-20, 20), rnd(-20, 20), rnd(-20, 20), rnd(-20, 20),
            rnd(-20, 20), rnd(-20, 20), rnd(-20, 20), rnd(-20, 20));
    launch(1'b1, 1'b0);
    wait_idle();

    // Ten back-to-back operations with start held high.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      set_ops(rnd(-20, 20), rnd(-20, 20), rnd(-20, 20), rnd(-20, 20),
              rnd(-20, 20), rnd(-20, 20), rnd(-20, 20), rnd(-20, 20));
      drive_ops();
      start = 1'b1;
      @(posedge clk);
      #1;
      sbq.push_back(model(av, bv, cyc));
      if (k < 9) begin
        repeat (9) begin
          @(negedge clk);
          rand_ports(-20, 20);
        end
      end
    end
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);

    chk("queue_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
